// File: rtl/cla_serial_sub.sv
// Multi-cycle subtractor: one 4-bit borrow-lookahead slice per clock, LSB first.
// Valid/ready on both sides; one operation in flight at a time.
module cla_serial_sub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, diff_q, diff_nx;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             bout_q, ovf_q, zero_q;

  logic [3:0] ai, bi, g, p, sd;
  logic [4:0] c;
  logic       last, load, step;

  assign last = (cnt_q == CW'(NSLICE - 1));

  // Borrow-lookahead across one nibble, all four borrows from c0 directly.
  always_comb begin
    ai = '0;
    bi = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (cnt_q == CW'(i)) begin
        ai = a_q[4*i +: 4];
        bi = b_q[4*i +: 4];
      end
    end
    g = ~ai & bi;
    p = ~(ai ^ bi);
    c[0] = br_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0])
         | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sd = ai ^ bi ^ c[3:0];
    diff_nx = diff_q;
    for (int i = 0; i < NSLICE; i++) begin
      if (cnt_q == CW'(i)) begin
        diff_nx[4*i +: 4] = sd;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    load = 1'b0;
    step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          load = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      br_q <= 1'b0;
      cnt_q <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        a_q <= a;
        b_q <= b;
        br_q <= bin;
        cnt_q <= '0;
      end
      if (step) begin
        diff_q <= diff_nx;
        br_q <= c[4];
        cnt_q <= cnt_q + CW'(1);
        if (last) begin
          bout_q <= c[4];
          ovf_q <= (a_q[MSB] ^ b_q[MSB])
                 & (a_q[MSB] ^ diff_nx[MSB]);
          zero_q <= (diff_nx == '0);
        end
      end
    end
  end

  assign in_ready = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_cla_serial_sub.sv
// Bench for cla_serial_sub: directed corner cases plus randomised ops
// with output stalls, checked against an integer-arithmetic model.
module tb_cla_serial_sub;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout, ovf, zero;

  int nchecks = 0;
  int nerrs = 0;

  cla_serial_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchecks++;
    if (obs !== exp) begin
      nerrs++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [W-1:0] ma,
                       input logic [W-1:0] mb,
                       input logic mbin,
                       output logic [W-1:0] ed,
                       output logic eb,
                       output logic eo,
                       output logic ez);
    int ua, ub, sa, sb, r, sr;
    ua = int'(ma);
    ub = int'(mb);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    r = ua - ub - int'(mbin);
    sr = sa - sb - int'(mbin);
    ed = W'((r + 65536) % 65536);
    eb = (ua < ub + int'(mbin));
    eo = (sr > 32767) || (sr < -32768);
    ez = (ed == '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag,
                         input logic [W-1:0] ed,
                         input logic eb, eo, ez);
    chk({tag, ".diff"}, 32'(diff), 32'(ed));
    chk({tag, ".bout"}, 32'(bout), 32'(eb));
    chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
    chk({tag, ".zero"}, 32'(zero), 32'(ez));
  endtask

  // Issue one op, wait for result, stall for nst cycles, then drain.
  task automatic run_op(input string tag,
                        input logic [W-1:0] ta,
                        input logic [W-1:0] tb_,
                        input logic tbin,
                        input int nst);
    logic [W-1:0] ed;
    logic eb, eo, ez;
    int lat;
    model(ta, tb_, tbin, ed, eb, eo, ez);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    a = ta;
    b = tb_;
    bin = tbin;
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      a = W'($urandom);
      b = W'($urandom);
      tick();
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'd4);
    chk_out(tag, ed, eb, eo, ez);
    for (int i = 0; i < nst; i++) begin
      in_valid = 1'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      bin = 1'($urandom);
      tick();
      chk({tag, ".stall_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".stall_ready"}, 32'(in_ready), 32'd0);
      chk_out({tag, ".stall"}, ed, eb, eo, ez);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".drain_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".drain_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".drain_diff"}, 32'(diff), 32'(ed));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst = 1'b1;
    in_valid = 1'b1;
    a = 16'hFFFF;
    b = 16'h0001;
    bin = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk_out("rst", '0, 1'b0, 1'b0, 1'b0);

    run_op("t1", 16'h1234, 16'h0234, 1'b0, 0);
    run_op("t2a", 16'h0000, 16'h0001, 1'b0, 0);
    run_op("t2b", 16'h8000, 16'h0001, 1'b0, 0);
    run_op("t3a", 16'h00F0, 16'h000F, 1'b1, 0);
    run_op("t3b", 16'h5A5A, 16'h5A5A, 1'b0, 0);
    run_op("t3c", 16'h5A5A, 16'h5A5A, 1'b1, 0);
    run_op("t4", 16'h7FFF, 16'hFFFF, 1'b0, 5);

    // Reset while the third slice is being computed.
    a = 16'h4321;
    b = 16'h1234;
    bin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5.out_valid", 32'(out_valid), 32'd0);
    chk("t5.in_ready", 32'(in_ready), 32'd1);
    chk_out("t5", '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5.no_stale", 32'(out_valid), 32'd0);
    end
    run_op("t5op", 16'h0010, 16'h0001, 1'b0, 0);

    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? ra : W'($urandom);
      run_op("rnd", ra, rb, 1'($urandom),
             ($urandom_range(0, 3) == 0) ?
               int'($urandom_range(1, 4)) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             nchecks, nerrs);
    $finish;
  end

endmodule
